// File: rtl/fft_digit_reorder.sv
// fft_digit_reorder
// Reorders digit-reversed radix-4 SDF FFT output into natural bin order.
// A ping-pong pair of frame buffers lets one frame be written while the
// previous one is read out, so contiguous frames stream without gaps.
module fft_digit_reorder #(
  parameter  int WIDTH = 32,
  parameter  int LOG4N = 2,
  localparam int N     = 4 ** LOG4N,
  localparam int AW    = 2 * LOG4N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             input_en,
  input  logic [WIDTH-1:0] input_real,
  input  logic [WIDTH-1:0] input_imag,
  input  logic             input_clear,
  output logic             output_en,
  output logic [WIDTH-1:0] output_real,
  output logic [WIDTH-1:0] output_imag,
  output logic [AW-1:0]    output_index,
  output logic             output_first
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  // Both banks live in one array; the MSB of the address selects the bank.
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  logic          bankSel_q, bankSel_d;
  logic [AW-1:0] wrCnt_q, wrCnt_d;
  logic [AW-1:0] rdCnt_q, rdCnt_d;
  logic          rdActive_q, rdActive_d;
  logic          frameDone;
  logic [AW-1:0] wrAddr;
  logic [AW:0]   wrMemAddr;
  logic [AW:0]   rdMemAddr;
  logic [2*WIDTH-1:0] rdWord;

  // Reverse the order of the 2-bit radix-4 digits; bits inside a digit stay put.
  function automatic logic [AW-1:0] rev4(input logic [AW-1:0] x);
    logic [AW-1:0] r;
    r = '0;
    for (int d = 0; d < LOG4N; d++) begin
      r[2*d +: 2] = x[2*(LOG4N-1-d) +: 2];
    end
    return r;
  endfunction

  // Next-state for write counter, bank select and the read engine.
  // A clear always wins over frame completion, so a clear on the last
  // write slot neither swaps banks nor starts a read.
  always_comb begin
    frameDone  = input_en && !input_clear && (wrCnt_q == LAST);
    wrAddr     = input_clear ? '0 : wrCnt_q;
    wrCnt_d    = wrCnt_q;
    bankSel_d  = bankSel_q;
    rdCnt_d    = rdCnt_q;
    rdActive_d = rdActive_q;

    if (input_clear) begin
      wrCnt_d = input_en ? AW'(1) : '0;
    end else if (input_en) begin
      wrCnt_d = wrCnt_q + AW'(1);
    end

    if (frameDone) begin
      bankSel_d  = ~bankSel_q;
      rdCnt_d    = '0;
      rdActive_d = 1'b1;
    end else if (rdActive_q) begin
      rdCnt_d    = rdCnt_q + AW'(1);
      rdActive_d = (rdCnt_q != LAST);
    end

    wrMemAddr = {bankSel_q, wrAddr};
    rdMemAddr = {~bankSel_q, rev4(rdCnt_q)};
    rdWord    = mem[rdMemAddr];
  end

  // Sample storage; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (input_en) begin
      mem[wrMemAddr] <= {input_real, input_imag};
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bankSel_q  <= 1'b0;
      wrCnt_q    <= '0;
      rdCnt_q    <= '0;
      rdActive_q <= 1'b0;
    end else begin
      bankSel_q  <= bankSel_d;
      wrCnt_q    <= wrCnt_d;
      rdCnt_q    <= rdCnt_d;
      rdActive_q <= rdActive_d;
    end
  end

  // Output register: data and index hold while idle, strobes drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      output_en    <= 1'b0;
      output_first <= 1'b0;
      output_real  <= '0;
      output_imag  <= '0;
      output_index <= '0;
    end else begin
      output_en    <= rdActive_q;
      output_first <= rdActive_q && (rdCnt_q == '0);
      if (rdActive_q) begin
        output_real  <= rdWord[2*WIDTH-1:WIDTH];
        output_imag  <= rdWord[WIDTH-1:0];
        output_index <= rdCnt_q;
      end
    end
  end

endmodule

// File: tb/tb_fft_digit_reorder.sv
// tb_fft_digit_reorder
// Scoreboard bench: the driver keeps a model of the write bank and, when a
// frame completes, queues the natural-order samples with the cycle on which
// each must appear. A negedge monitor pops and compares them.
module tb_fft_digit_reorder;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          inEn;
  logic [W-1:0]  inReal;
  logic [W-1:0]  inImag;
  logic          inClear;
  logic          outEn;
  logic [W-1:0]  outReal;
  logic [W-1:0]  outImag;
  logic [3:0]    outIndex;
  logic          outFirst;

  logic          en64;
  logic [W-1:0]  real64;
  logic [W-1:0]  imag64;
  logic          clear64;
  logic          outEn64;
  logic [W-1:0]  outReal64;
  logic [W-1:0]  outImag64;
  logic [5:0]    outIndex64;
  logic          outFirst64;

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [3:0]   idx;
    logic         first;
  } exp_t;

  exp_t sbq[$];
  logic [2*W-1:0] modelMem [0:15];
  int modelCnt = 0;

  fft_digit_reorder #(.WIDTH(W), .LOG4N(2)) dut (
    .clock(clock), .reset(reset),
    .input_en(inEn), .input_real(inReal), .input_imag(inImag),
    .input_clear(inClear),
    .output_en(outEn), .output_real(outReal), .output_imag(outImag),
    .output_index(outIndex), .output_first(outFirst)
  );

  fft_digit_reorder #(.WIDTH(W), .LOG4N(3)) dut64 (
    .clock(clock), .reset(reset),
    .input_en(en64), .input_real(real64), .input_imag(imag64),
    .input_clear(clear64),
    .output_en(outEn64), .output_real(outReal64), .output_imag(outImag64),
    .output_index(outIndex64), .output_first(outFirst64)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges so expected samples can carry their due cycle.
  always @(posedge clock) cyc <= cyc + 1;

  // For N=16 a natural index k lives at digit-reversed address (k%4)*4 + k/4.
  function automatic int srcAddr16(input int k);
    return (k % 4) * 4 + k / 4;
  endfunction

  // Monitor: compare every valid output against the scoreboard head and
  // flag samples that failed to appear on their due cycle.
  always @(negedge clock) begin
    exp_t e;
    if (outEn) begin
      if (sbq.size() == 0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL unexpected_output: got index %0d real %0h, expected no output", outIndex, outReal);
      end else begin
        e = sbq.pop_front();
        vectors += 5;
        if (cyc !== e.cyc) begin
          miscompares++;
          $display("[TB] FAIL out_cycle: got cycle %0d, expected %0d", cyc, e.cyc);
        end
        if (outReal !== e.re) begin
          miscompares++;
          $display("[TB] FAIL out_real k=%0d: got %0h, expected %0h", e.idx, outReal, e.re);
        end
        if (outImag !== e.im) begin
          miscompares++;
          $display("[TB] FAIL out_imag k=%0d: got %0h, expected %0h", e.idx, outImag, e.im);
        end
        if (outIndex !== e.idx) begin
          miscompares++;
          $display("[TB] FAIL out_index: got %0d, expected %0d", outIndex, e.idx);
        end
        if (outFirst !== e.first) begin
          miscompares++;
          $display("[TB] FAIL out_first k=%0d: got %0b, expected %0b", e.idx, outFirst, e.first);
        end
      end
    end else begin
      if (outFirst !== 1'b0) begin
        vectors++; miscompares++;
        $display("[TB] FAIL first_while_idle: got %0b, expected 0", outFirst);
      end
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        vectors++; miscompares++;
        $display("[TB] FAIL missing_output k=%0d: got output_en 0 at cycle %0d, expected 1", e.idx, cyc);
      end
    end
  end

  // Drive one input cycle and advance the write-bank model; a completed
  // frame queues its 16 natural-order samples.
  task automatic applyStimulus(input logic en, input logic clr, input logic [W-1:0] re, input logic [W-1:0] im);
    exp_t e;
    int addr;
    int unsigned base;
    @(negedge clock);
    inEn = en; inClear = clr; inReal = re; inImag = im;
    if (en) begin
      addr = clr ? 0 : modelCnt;
      modelMem[addr] = {re, im};
    end
    if (clr) begin
      modelCnt = en ? 1 : 0;
    end else if (en) begin
      if (modelCnt == 15) begin
        base = cyc + 2;
        for (int k = 0; k < 16; k++) begin
          e.cyc   = base + k;
          e.re    = modelMem[srcAddr16(k)][2*W-1:W];
          e.im    = modelMem[srcAddr16(k)][W-1:0];
          e.idx   = 4'(k);
          e.first = (k == 0);
          sbq.push_back(e);
        end
        modelCnt = 0;
      end else begin
        modelCnt++;
      end
    end
  endtask

  // Wait (bounded) until every queued sample has been observed.
  task automatic waitDrain(input string name);
    for (int i = 0; i < 200 && sbq.size() > 0; i++) begin
      @(negedge clock); #1;
    end
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: got %0d samples outstanding, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    vectors += 5;
    if (outEn !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en: got %0b, expected 0", outEn); end
    if (outFirst !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_first: got %0b, expected 0", outFirst); end
    if (outReal !== '0) begin miscompares++; $display("[TB] FAIL reset_real: got %0h, expected 0", outReal); end
    if (outImag !== '0) begin miscompares++; $display("[TB] FAIL reset_imag: got %0h, expected 0", outImag); end
    if (outIndex !== '0) begin miscompares++; $display("[TB] FAIL reset_index: got %0d, expected 0", outIndex); end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, W'(i), W'(-i));
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitDrain("single");
    @(negedge clock); #1;
    vectors += 4;
    if (outEn !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_en: got %0b, expected 0", outEn); end
    if (outReal !== W'(15)) begin miscompares++; $display("[TB] FAIL hold_real: got %0h, expected f", outReal); end
    if (outImag !== W'(-15)) begin miscompares++; $display("[TB] FAIL hold_imag: got %0h, expected %0h", outImag, W'(-15)); end
    if (outIndex !== 4'd15) begin miscompares++; $display("[TB] FAIL hold_index: got %0d, expected 15", outIndex); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, W'(16*f + i), ~W'(16*f + i));
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitDrain("back_to_back");
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 1'b0, W'(i/2), W'(-(i/2)));
      else applyStimulus(1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    end
    waitDrain("gapped");
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, W'(200 + i), W'(300 + i));
    applyStimulus(1'b1, 1'b1, W'(100), W'(-100));
    for (int i = 1; i < 16; i++) applyStimulus(1'b1, 1'b0, W'(i), W'(-i));
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitDrain("clear");
    // Clear on the final write slot: no frame may come out of it.
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, W'(400 + i), '0);
    applyStimulus(1'b1, 1'b1, W'(77), W'(78));
    for (int i = 1; i < 16; i++) applyStimulus(1'b1, 1'b0, W'(600 + i), W'(700 + i));
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitDrain("clear_last");
  endtask

  task automatic test_reset_mid_read();
    bit found = 0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, W'(500 + i), W'(900 + i));
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock); #1;
      if (outEn && outIndex == 4'd5) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("[TB] FAIL reset_wait_k5: got no k=5 output, expected one"); end
    #2 reset = 1'b1;
    #1;
    vectors += 4;
    if (outEn !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_en: got %0b, expected 0", outEn); end
    if (outReal !== '0) begin miscompares++; $display("[TB] FAIL midreset_real: got %0h, expected 0", outReal); end
    if (outImag !== '0) begin miscompares++; $display("[TB] FAIL midreset_imag: got %0h, expected 0", outImag); end
    if (outIndex !== '0) begin miscompares++; $display("[TB] FAIL midreset_index: got %0d, expected 0", outIndex); end
    sbq.delete();
    modelCnt = 0;
    @(negedge clock);
    reset = 1'b0;
    repeat (20) applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, W'(800 + i), W'(i));
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitDrain("after_reset");
  endtask

  task automatic test_log4n3();
    int seen = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      en64 = 1'b1; real64 = W'(i); imag64 = '0;
    end
    @(negedge clock);
    en64 = 1'b0;
    for (int i = 0; i < 200 && seen < 3; i++) begin
      @(negedge clock); #1;
      if (outEn64) begin
        if (outIndex64 == 6'd1) begin
          seen++; vectors++;
          if (outReal64 !== W'(16)) begin miscompares++; $display("[TB] FAIL n64_k1: got %0d, expected 16", outReal64); end
        end else if (outIndex64 == 6'd6) begin
          seen++; vectors++;
          if (outReal64 !== W'(36)) begin miscompares++; $display("[TB] FAIL n64_k6: got %0d, expected 36", outReal64); end
        end else if (outIndex64 == 6'd63) begin
          seen++; vectors++;
          if (outReal64 !== W'(63)) begin miscompares++; $display("[TB] FAIL n64_k63: got %0d, expected 63", outReal64); end
        end
      end
    end
    vectors++;
    if (seen != 3) begin miscompares++; $display("[TB] FAIL n64_seen: got %0d checkpoints, expected 3", seen); end
  endtask

  // Run all scenarios in order, then report.
  initial begin
    reset = 1'b1;
    inEn = 1'b0; inClear = 1'b0; inReal = '0; inImag = '0;
    en64 = 1'b0; clear64 = 1'b0; real64 = '0; imag64 = '0;
    repeat (3) @(negedge clock);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_clear();
    test_reset_mid_read();
    test_log4n3();
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_digit_reorder.md
FFT_DIGIT_REORDER -- requirements
Module: fft_digit_reorder

Interface
REQ-001 Parameter WIDTH, default 32, packed sample width per component (real, imag).
REQ-002 Parameter LOG4N, default 2, radix-4 digit count; frame length N = 4^LOG4N (16 at default); AW = 2*LOG4N.
REQ-003 clock  input  1  master clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 input_en  input  1  input sample valid; one sample accepted per clock while high.
REQ-006 input_real  input  WIDTH  input sample, real part; digit-reversed order as produced by the radix-4 SDF stage chain.
REQ-007 input_imag  input  WIDTH  input sample, imaginary part.
REQ-008 input_clear  input  1  synchronous discard of the partially written frame.
REQ-009 output_en  output  1  output sample valid.
REQ-010 output_real  output  WIDTH  output sample, real part, natural order.
REQ-011 output_imag  output  WIDTH  output sample, imaginary part, natural order.
REQ-012 output_index  output  AW  natural-order bin index k of the current output sample.
REQ-013 output_first  output  1  high with the k = 0 sample of each frame.

Function
REQ-014 Storage: two banks (ping-pong) of N x 2*WIDTH words; one bank is write bank, the other read bank.
REQ-015 Write: on each edge with input_en high, store {input_real, input_imag} at write bank address wr_cnt, then wr_cnt increments.
REQ-016 Gaps in input_en pause wr_cnt; no sample is lost or duplicated.
REQ-017 Frame complete: on the edge writing address N-1, wr_cnt wraps to 0, write/read bank roles swap, read engine starts with rd_cnt = 0.
REQ-018 Read: while active, on each edge output_real/imag <= read bank [rev4(rd_cnt)], output_index <= rd_cnt, output_en <= 1, rd_cnt increments.
REQ-019 rev4(x): reverse order of the LOG4N 2-bit digits of x; bits within a digit are not swapped (N=16: rev4(1)=4, rev4(6)=9).
REQ-020 Read emits exactly N samples back to back, without stalls; engine goes idle after rd_cnt = N-1 unless a new frame completes on that edge.
REQ-021 Latency: first output (output_en, output_first high) on the edge after the edge writing sample N-1; last output N-1 edges later.
REQ-022 Back-to-back frames: completion edge coinciding with the last read edge restarts rd_cnt = 0; output_en stays high without a gap.
REQ-023 Overrun cannot occur: a frame needs at least N input cycles, read takes exactly N; no overflow flag.
REQ-024 When output_en low: output_real, output_imag, output_index hold their last values; output_first low.
REQ-025 input_clear: wr_cnt <= 0 and write bank contents are treated as invalid; an active read in the read bank is unaffected.
REQ-026 input_clear with input_en on the same edge: the sample is written at address 0 and wr_cnt <= 1.
REQ-027 input_clear on the edge where wr_cnt = N-1 with input_en: clear wins; no swap, no read start.
REQ-028 Data passes bit-exact; no arithmetic, rounding, or sign handling.

Reset
REQ-029 On reset: output_en = 0, output_first = 0, output_real = 0, output_imag = 0, output_index = 0, wr_cnt = 0, rd_cnt = 0, read engine idle, bank select = 0.
REQ-030 Memory contents are not reset; no output is produced from them until a full frame completes after reset.
REQ-031 Reset asserted mid-frame or mid-read: partial frame and the remaining read samples are discarded; the next full frame after release is output normally.

Verification
REQ-032 N=16, 16 contiguous inputs real=i, imag=-i (i=0..15) -> output_en for 16 cycles starting one edge after the last input; real sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; output_first on first; output_index 0..15.
REQ-033 Three frames contiguous (48 input cycles) -> 48 contiguous output_en cycles; each frame reordered independently, output_first every 16 cycles.
REQ-034 Frame with input_en toggling 1-0 (32 cycles) -> identical output sequence to REQ-032, starting one edge after the 16th accepted sample.
REQ-035 8 samples, then input_clear with input_en (value 100), then 15 more samples -> one frame output; rev4 position 0 carries 100; the first 8 samples never appear.
REQ-036 Reset pulsed at output sample k=5 of a frame -> outputs zero, output_en low immediately; no further output until a fresh 16-sample frame completes.
REQ-037 LOG4N=3 (N=64), input real=i -> output at k=1 is 16, k=6 is 36, k=63 is 63.
